key_expand: RTL and testbench
=============================

KEY_EXPAND -- requirements
Module: key_expand

Interface
REQ-001 SHALL have parameter KEY_BITS, default 128, AES key length; legal values 128, 192, 256; any other value fails elaboration.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new key expansion; sampled only in IDLE.
REQ-005 SHALL have port key_in  input  KEY_BITS  cipher key; word 0 in the MSBs; byte 0 of each word in bits [31:24].
REQ-006 SHALL have port rk_out  output  128  current round key; word 0 in bits [127:96].
REQ-007 SHALL have port rk_idx  output  4  index of rk_out, 0..Nr.
REQ-008 SHALL have port rk_valid  output  1  rk_out and rk_idx are valid.
REQ-009 SHALL have port rk_ready  input  1  consumer accepts the round key when rk_valid && rk_ready.
REQ-010 SHALL have port busy  output  1  high from start acceptance until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the final handshake.

Function
REQ-012 Nk = KEY_BITS/32; Nr = Nk+6; total words 4*(Nr+1): 44, 52 or 60.
REQ-013 SHALL implement FSM IDLE -> GEN -> DRAIN -> IDLE; GEN while words remain, DRAIN while the last round key awaits handshake.
REQ-014 In IDLE, start=1 SHALL capture key_in into an Nk-word sliding window, clear word counter i, set busy, and enter GEN; start outside IDLE SHALL be ignored.
REQ-015 GEN SHALL produce one word w[i] per unstalled cycle: i<Nk -> key word i; i mod Nk = 0 -> w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ (Rcon[i/Nk] in byte 0); Nk=8 and i mod 8 = 4 -> w[i-8] ^ SubWord(w[i-1]); otherwise w[i-8..] i.e. w[i-Nk] ^ w[i-1].
REQ-016 RotWord SHALL move byte 0 to byte 3; Rcon sequence SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-017 Words SHALL accumulate in a 4-word staging register; on the 4th word the group SHALL transfer to rk_out with rk_idx = i/4 and rk_valid=1, if the output register is empty or being handshaken that cycle.
REQ-018 Generation SHALL stall when staging holds 4 words and the output register is full and not handshaken; no word is lost or duplicated.
REQ-019 Latency: start accepted at edge 0 -> rk_valid=1, rk_idx=0 after edge 4; with rk_ready held 1, one round key every 4 cycles.
REQ-020 rk_valid SHALL stay high and rk_out/rk_idx stable until handshake.
REQ-021 Handshake of rk_idx=Nr SHALL pulse done for one cycle, clear busy, return to IDLE; start in that same cycle is ignored.
REQ-022 Key changes on key_in after acceptance SHALL have no effect.

Reset
REQ-023 rst_n=0 SHALL, at any time including mid-expansion, force IDLE, rk_out=0, rk_idx=0, rk_valid=0, busy=0, done=0, clear window, staging and counter.

Configuration
REQ-024 Macro KEY_EXPAND_ZEROIZE_EN defined: on the done cycle, window, staging and rk_out SHALL be cleared to 0; undefined: they retain last values.

Structure
REQ-025 Package aes_pkg SHALL hold the Rcon table, the Nk/Nr constants per key size and the FSM state typedef.
REQ-026 Combinational byte substitution SHALL be sub-module aes_sbox (8-bit in, 8-bit out), instantiated 4 times.

Verification
REQ-027 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx1 a0fafe1788542cb123a339392a6c7605, idx10 d014f9a8c9ee2589e13f0cc8b6630ca6, done after idx10.
REQ-028 KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> idx12 e98ba06f448c773c8ecc720401002202.
REQ-029 KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> idx14 fe4890d1e6188d0b046df344706c631e.
REQ-030 Random rk_ready back-pressure (including 20-cycle stall at idx5) -> identical key sequence, rk_out stable while stalled.
REQ-031 rst_n low during idx3 -> all outputs 0 next sample; new start then yields idx0 = key_in.
REQ-032 start pulsed while busy -> ignored, sequence unchanged; with KEY_EXPAND_ZEROIZE_EN, rk_out=0 after done.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-size constants, Rcon table and controller state encoding.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_DRAIN = 2'd2
    } ke_state_t;

    localparam int NK_128 = 4;
    localparam int NK_192 = 6;
    localparam int NK_256 = 8;
    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    // Rcon[1] in the top byte through Rcon[10] in the bottom byte.
    localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        r = 8'h00;
        if (rnd >= 4'd1 && rnd <= 4'd10) begin
            r = RCON_TBL[8*(10-int'(rnd)) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) inverse by x^254 followed by the affine transform.
// Latency: purely combinational.
// Backpressure: none; no state.
module aes_sbox (
    input  logic [7:0] byte_dat,
    output logic [7:0] sub_dat
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = x;
        bb = y;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Addition chain for x^254, which is the multiplicative inverse (and maps 0 to 0).
    always_comb begin
        x2   = gf_mul(byte_dat, byte_dat);
        x3   = gf_mul(x2, byte_dat);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
    end

    assign sub_dat = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/key_expand.sv
// AES-128/192/256 key expansion, one schedule word per cycle, grouped into 128-bit round keys.
// Latency: first round key valid 4 cycles after start is accepted, then one every 4 cycles.
// Backpressure: rk_valid/rk_ready; generation stalls when staging is full and rk_out is unaccepted.
// Build option KEY_EXPAND_ZEROIZE_EN: window, staging and rk_out are cleared on the done cycle.
module key_expand
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic [127:0]        rk_out,
    output logic [3:0]          rk_idx,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic                busy,
    output logic                done
);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $fatal(1, "key_expand: KEY_BITS must be 128, 192 or 256");
    end

    localparam int NK = (KEY_BITS == 256) ? NK_256 : (KEY_BITS == 192) ? NK_192 : NK_128;
    localparam int NR = (KEY_BITS == 256) ? NR_256 : (KEY_BITS == 192) ? NR_192 : NR_128;
    localparam logic [5:0] LAST_I  = 6'(4*(NR+1)-1);
    localparam logic [5:0] NK_I    = 6'(NK);
    localparam logic [2:0] NK_LAST = 3'(NK-1);

    ke_state_t           state, state_nxt;
    logic [KEY_BITS-1:0] win;
    logic [95:0]         stg;
    logic [1:0]          stg_cnt;
    logic [5:0]          i;
    logic [2:0]          j;
    logic [3:0]          rc;
    logic [31:0]         prev_w, old_w, rot_w, sb_in, sb_out, new_word;
    logic                gen_fire, grp_load, final_hs;

    // win holds w[i-Nk] in the MSBs through w[i-1] in the LSBs; while i < Nk it simply rotates the key.
    assign old_w  = win[KEY_BITS-1 -: 32];
    assign prev_w = win[31:0];
    assign rot_w  = {prev_w[23:0], prev_w[31:24]};
    assign sb_in  = (NK == 8 && j == 3'd4) ? prev_w : rot_w;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_dat(sb_in[8*b +: 8]),
            .sub_dat (sb_out[8*b +: 8])
        );
    end

    always_comb begin
        new_word = old_w ^ prev_w;
        if (i < NK_I) begin
            new_word = old_w;
        end else if (j == 3'd0) begin
            new_word = old_w ^ sb_out ^ {rcon(rc), 24'h000000};
        end else if (NK == 8 && j == 3'd4) begin
            new_word = old_w ^ sb_out;
        end
    end

    assign gen_fire = (state == ST_GEN) && !(stg_cnt == 2'd3 && rk_valid && !rk_ready);
    assign grp_load = gen_fire && (stg_cnt == 2'd3);
    assign final_hs = (state == ST_DRAIN) && rk_valid && rk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_GEN;
            ST_GEN:   if (gen_fire && i == LAST_I) state_nxt = ST_DRAIN;
            ST_DRAIN: if (final_hs) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win      <= '0;
            stg      <= '0;
            stg_cnt  <= '0;
            i        <= '0;
            j        <= '0;
            rc       <= '0;
            rk_out   <= '0;
            rk_idx   <= '0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= final_hs;
            if (state == ST_IDLE && start) begin
                win     <= key_in;
                i       <= '0;
                j       <= '0;
                rc      <= '0;
                stg_cnt <= '0;
            end else if (gen_fire) begin
                win <= {win[KEY_BITS-33:0], new_word};
                i   <= i + 6'd1;
                if (j == NK_LAST) begin
                    j  <= '0;
                    rc <= rc + 4'd1;
                end else begin
                    j <= j + 3'd1;
                end
                if (stg_cnt == 2'd3) begin
                    stg_cnt <= '0;
                end else begin
                    stg     <= {stg[63:0], new_word};
                    stg_cnt <= stg_cnt + 2'd1;
                end
            end
            // The 4th word bypasses staging straight into the output register.
            if (grp_load) begin
                rk_out   <= {stg, new_word};
                rk_idx   <= i[5:2];
                rk_valid <= 1'b1;
            end else if (rk_valid && rk_ready) begin
                rk_valid <= 1'b0;
            end
`ifdef KEY_EXPAND_ZEROIZE_EN
            if (final_hs) begin
                win    <= '0;
                stg    <= '0;
                rk_out <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_key_expand.sv
// Scoreboard bench for key_expand at 128/192/256-bit key sizes, with back-pressure and reset cases.
`timescale 1ns/1ps
module tb_key_expand;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start;
    logic         rk_ready;
    logic [255:0] key_s;
    int           sel;

    logic         st128, st192, st256, rd128, rd192, rd256;
    logic [127:0] out128, out192, out256;
    logic [3:0]   idx128, idx192, idx256;
    logic         vld128, vld192, vld256;
    logic         busy128, busy192, busy256;
    logic         done128, done192, done256;

    assign st128 = start && (sel == 0);
    assign st192 = start && (sel == 1);
    assign st256 = start && (sel == 2);
    assign rd128 = rk_ready && (sel == 0);
    assign rd192 = rk_ready && (sel == 1);
    assign rd256 = rk_ready && (sel == 2);

    key_expand #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst_n(rst_n), .start(st128), .key_in(key_s[255:128]),
        .rk_out(out128), .rk_idx(idx128), .rk_valid(vld128), .rk_ready(rd128),
        .busy(busy128), .done(done128));
    key_expand #(.KEY_BITS(192)) u192 (
        .clk(clk), .rst_n(rst_n), .start(st192), .key_in(key_s[255:64]),
        .rk_out(out192), .rk_idx(idx192), .rk_valid(vld192), .rk_ready(rd192),
        .busy(busy192), .done(done192));
    key_expand #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst_n(rst_n), .start(st256), .key_in(key_s),
        .rk_out(out256), .rk_idx(idx256), .rk_valid(vld256), .rk_ready(rd256),
        .busy(busy256), .done(done256));

    logic [127:0] obs_out;
    logic [3:0]   obs_idx;
    logic         obs_vld, obs_busy, obs_done;

    always_comb begin
        case (sel)
            1: begin obs_out = out192; obs_idx = idx192; obs_vld = vld192; obs_busy = busy192; obs_done = done192; end
            2: begin obs_out = out256; obs_idx = idx256; obs_vld = vld256; obs_busy = busy256; obs_done = done256; end
            default: begin obs_out = out128; obs_idx = idx128; obs_vld = vld128; obs_busy = busy128; obs_done = done128; end
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    // Reference model: S-box built by walking the multiplicative group, plain FIPS-197 word loop.
    logic [7:0]   sbox [0:255];
    logic [31:0]  mw   [0:59];
    logic [131:0] exp_q [$];

    task automatic build_sbox;
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    function automatic logic [7:0] model_rcon(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < n; k++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        return r;
    endfunction

    task automatic model_expand(input logic [255:0] k, input int nk);
        logic [31:0] t;
        for (int n = 0; n < nk; n++) mw[n] = k[255-32*n -: 32];
        for (int n = nk; n < 4*(nk+7); n++) begin
            t = mw[n-1];
            if (n % nk == 0)               t = sub_w({t[23:0], t[31:24]}) ^ {model_rcon(n/nk), 24'h0};
            else if (nk > 6 && n % nk == 4) t = sub_w(t);
            mw[n] = mw[n-nk] ^ t;
        end
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; sel = 0; key_s = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out128, idx128, vld128, busy128, done128} !== 135'h0) begin
            n_errors++;
            $display("FAIL reset_128: got out=%h idx=%0d vld=%b busy=%b done=%b want all 0", out128, idx128, vld128, busy128, done128);
        end
        n_checks++;
        if ({out192, idx192, vld192, busy192, done192, out256, idx256, vld256, busy256, done256} !== 270'h0) begin
            n_errors++;
            $display("FAIL reset_192_256: got vld=%b%b busy=%b%b out192=%h out256=%h want all 0", vld192, vld256, busy192, busy256, out192, out256);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy128 !== 1'b0 || vld128 !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: got busy=%b vld=%b want 0 0", busy128, vld128);
        end
    endtask

    // mode 0: rk_ready held 1; mode 1: random back-pressure plus a 20-cycle stall at idx5;
    // mode 2: rk_ready held 1 while start pulses and key_in churns during the expansion.
    task automatic test_expansion(input int sel_i, input int mode, input logic [255:0] key);
        int nk, nr, cyc, stall;
        bit stalled_once, finished, has_vec;
        logic [131:0] e;
        logic [127:0] last_key, vec;
        sel = sel_i;
        nk  = 4 + 2*sel_i;
        nr  = nk + 6;
        key_s = key;
        model_expand(key, nk);
        exp_q.delete();
        for (int r = 0; r <= nr; r++)
            exp_q.push_back({4'(r), mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
        last_key = '0;
        start = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (obs_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_after_start sel=%0d: got %b want 1", sel_i, obs_busy);
        end
        cyc = 0; stall = 0; stalled_once = 0; finished = 0;
        while (!finished && cyc < 2000) begin
            if (mode == 1) begin
                if (stall > 0) begin
                    rk_ready = 1'b0; stall--;
                end else if (obs_vld && obs_idx == 4'd5 && !stalled_once) begin
                    stalled_once = 1; stall = 19; rk_ready = 1'b0;
                end else begin
                    rk_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                rk_ready = 1'b1;
            end
            if (mode == 2) begin
                start = (cyc % 3 == 1);
                key_s = rand_key();
            end
            if (mode == 0 && cyc < 4) begin
                n_checks++;
                if (obs_vld !== 1'b0) begin
                    n_errors++;
                    $display("FAIL early_valid sel=%0d cyc=%0d: got %b want 0", sel_i, cyc, obs_vld);
                end
            end
            if (mode == 0 && cyc == 4) begin
                n_checks++;
                if (obs_vld !== 1'b1 || obs_idx !== 4'd0) begin
                    n_errors++;
                    $display("FAIL first_latency sel=%0d: got vld=%b idx=%0d want 1 0", sel_i, obs_vld, obs_idx);
                end
            end
            if (obs_vld) begin
                e = exp_q[0];
                n_checks++;
                if ({obs_idx, obs_out} !== e) begin
                    n_errors++;
                    $display("FAIL round_key sel=%0d mode=%0d: got idx=%0d %h want idx=%0d %h", sel_i, mode, obs_idx, obs_out, e[131:128], e[127:0]);
                end
                if (rk_ready) begin
                    if (mode == 0) begin
                        n_checks++;
                        if (cyc != 4*(int'(e[131:128])+1)) begin
                            n_errors++;
                            $display("FAIL key_rate sel=%0d idx=%0d: got cycle %0d want %0d", sel_i, e[131:128], cyc, 4*(int'(e[131:128])+1));
                        end
                    end
                    has_vec = 1'b1;
                    if (sel_i == 0 && obs_idx == 4'd1)       vec = 128'ha0fafe1788542cb123a339392a6c7605;
                    else if (sel_i == 0 && obs_idx == 4'd10) vec = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
                    else if (sel_i == 1 && obs_idx == 4'd12) vec = 128'he98ba06f448c773c8ecc720401002202;
                    else if (sel_i == 2 && obs_idx == 4'd14) vec = 128'hfe4890d1e6188d0b046df344706c631e;
                    else begin has_vec = 1'b0; vec = '0; end
                    if (has_vec) begin
                        n_checks++;
                        if (obs_out !== vec) begin
                            n_errors++;
                            $display("FAIL known_vector sel=%0d idx=%0d: got %h want %h", sel_i, obs_idx, obs_out, vec);
                        end
                    end
                    last_key = e[127:0];
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) finished = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        rk_ready = 1'b0;
        n_checks++;
        if (!finished) begin
            n_errors++;
            $display("FAIL timeout sel=%0d mode=%0d: got %0d keys left want 0", sel_i, mode, exp_q.size());
        end
        n_checks++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL done_pulse sel=%0d: got done=%b busy=%b vld=%b want 1 0 0", sel_i, obs_done, obs_busy, obs_vld);
        end
        n_checks++;
`ifdef KEY_EXPAND_ZEROIZE_EN
        if (obs_out !== 128'h0) begin
            n_errors++;
            $display("FAIL zeroize sel=%0d: got %h want 0", sel_i, obs_out);
        end
`else
        if (obs_out !== last_key) begin
            n_errors++;
            $display("FAIL retain_last sel=%0d: got %h want %h", sel_i, obs_out, last_key);
        end
`endif
        @(negedge clk);
        n_checks++;
        if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL done_one_cycle sel=%0d: got done=%b busy=%b want 0 0", sel_i, obs_done, obs_busy);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        logic [127:0] want;
        sel = 0;
        key_s = rand_key();
        rk_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(obs_vld && obs_idx == 4'd3) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= 100) begin
            n_errors++;
            $display("FAIL wait_idx3: got timeout after %0d cycles want idx3", cyc);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({obs_out, obs_idx, obs_vld, obs_busy, obs_done} !== 135'h0) begin
            n_errors++;
            $display("FAIL reset_mid: got out=%h idx=%0d vld=%b busy=%b done=%b want all 0", obs_out, obs_idx, obs_vld, obs_busy, obs_done);
        end
        rst_n = 1'b1;
        key_s = rand_key();
        want = key_s[255:128];
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!obs_vld && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (obs_vld !== 1'b1 || obs_idx !== 4'd0 || obs_out !== want) begin
            n_errors++;
            $display("FAIL restart_idx0: got vld=%b idx=%0d %h want 1 0 %h", obs_vld, obs_idx, obs_out, want);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rk_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_expansion(0, 0, K128);
        test_expansion(1, 0, K192);
        test_expansion(2, 0, K256);
        test_expansion(0, 1, K128);
        test_expansion(2, 1, K256);
        test_expansion(0, 2, K128);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
